alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational `alu` instance between two requesters (e.g. execute stage and a branch/address unit). Each requester issues an operation over a valid/ready handshake; the arbiter grants one, drives the shared ALU from registered operands, captures the result and zero flag, and returns them over a per-requester valid/ready response channel. It sits between the requesters and the `alu` instance and holds all sequencing state.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational ALU between
// two requesters. One operation is in flight at a time; each operation goes
// through IDLE (accept), EXEC (ALU evaluates registered operands) and RESP
// (result held until the owning requester consumes it).
module alu_arbiter #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [n-1:0] req0_srcA,
  input  logic [n-1:0] req0_srcB,
  input  logic [n-1:0] req1_srcA,
  input  logic [n-1:0] req1_srcB,
  input  logic [2:0]   req0_ctrl,
  input  logic [2:0]   req1_ctrl,
  output logic         resp0_valid,
  output logic         resp1_valid,
  input  logic         resp0_ready,
  input  logic         resp1_ready,
  output logic [n-1:0] resp_out,
  output logic         resp_zero,
  output logic [n-1:0] alu_srcA,
  output logic [n-1:0] alu_srcB,
  output logic [2:0]   alu_control,
  input  logic [n-1:0] alu_out,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_grant_q;
  logic         owner_q;
  logic [n-1:0] op_a_q;
  logic [n-1:0] op_b_q;
  logic [2:0]   op_ctrl_q;
  logic [n-1:0] resp_out_q;
  logic         resp_zero_q;

  logic         grant0;
  logic         grant1;
  logic         accept;
  logic         owner_ready;

  // Round-robin grant: a lone valid wins; on a tie the requester not served last wins
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  // Handshake and consume qualifiers shared by the FSM and the datapath
  assign accept      = (state_q == IDLE) & (grant0 | grant1);
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> one EXEC cycle -> RESP until the owner consumes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: readies only in IDLE, response valid only toward the owner
  always_comb begin
    req0_ready  = (state_q == IDLE) & grant0;
    req1_ready  = (state_q == IDLE) & grant1;
    resp0_valid = (state_q == RESP) & ~owner_q;
    resp1_valid = (state_q == RESP) &  owner_q;
  end

  // Datapath: latch the granted operation, capture the ALU result, update fairness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= 3'b000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_out_q   <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q    <= grant1 ? req1_srcA : req0_srcA;
        op_b_q    <= grant1 ? req1_srcB : req0_srcB;
        op_ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
        owner_q   <= grant1;
      end
      if (state_q == EXEC) begin
        resp_out_q  <= alu_out;
        resp_zero_q <= alu_zero;
      end
      if ((state_q == RESP) && owner_ready) begin
        last_grant_q <= owner_q;
      end
    end
  end

  // The shared ALU always sees the registered operation
  assign alu_srcA    = op_a_q;
  assign alu_srcB    = op_b_q;
  assign alu_control = op_ctrl_q;
  assign resp_out    = resp_out_q;
  assign resp_zero   = resp_zero_q;

endmodule
